// File: rtl/icache_control_pkg.sv
// Shared cache definitions: controller state encoding and default counter width.
package icache_control_pkg;

    localparam int CTR_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        SETTLE = 2'd2
    } state_t;

endpackage

// File: rtl/icache_control_sat_counter.sv
// Width-parameterised saturating event counter with synchronous clear.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/icache_control.sv
// Read-only instruction cache controller: zero-latency hits, single line fill per miss,
// plus saturating hit/miss performance counters.
module icache_control
    import icache_control_pkg::*;
#(
    parameter int CTR_WIDTH = CTR_WIDTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    output logic                 mem_resp,
    output logic                 pmem_read,
    input  logic                 pmem_resp,
    input  logic                 hit,
    output logic                 way_sel_method,
    output logic                 load_line_data,
    output logic                 load_valid,
    output logic                 valid_in,
    output logic                 load_LRU,
    output logic                 load_dirty,
    output logic                 dirty_in,
    output logic                 load_wdata_reg,
    output logic                 line_datain_sel,
    output logic                 address_sel,
    output logic                 rdata_sel,
    input  logic                 ctr_clear,
    output logic [CTR_WIDTH-1:0] hit_count,
    output logic [CTR_WIDTH-1:0] miss_count,
    output logic                 busy
);

    state_t state_reg;
    logic   post_fill_reg;
    logic   hit_inc;
    logic   miss_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            post_fill_reg <= 1'b0;
        end else begin
            // Set only for the IDLE cycle right after a fill, which replays the request as a hit.
            post_fill_reg <= (state_reg == SETTLE);
            case (state_reg)
                IDLE:    if (mem_read && !hit) state_reg <= FETCH;
                FETCH:   if (pmem_resp)        state_reg <= SETTLE;
                SETTLE:                        state_reg <= IDLE;
                default:                       state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        way_sel_method = 1'b0;
        load_line_data = 1'b0;
        load_valid     = 1'b0;
        valid_in       = 1'b0;
        load_LRU       = 1'b0;
        busy           = 1'b0;
        hit_inc        = 1'b0;
        miss_inc       = 1'b0;
        if (!rst) begin
            busy = (state_reg != IDLE);
            case (state_reg)
                IDLE: begin
                    if (mem_read && hit) begin
                        mem_resp = 1'b1;
                        load_LRU = 1'b1;
                        hit_inc  = !post_fill_reg;
                    end
                    miss_inc = mem_read && !hit;
                end
                FETCH: begin
                    pmem_read      = 1'b1;
                    way_sel_method = 1'b1;
                    if (pmem_resp) begin
                        load_line_data = 1'b1;
                        load_valid     = 1'b1;
                        valid_in       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign load_dirty      = 1'b0;
    assign dirty_in        = 1'b0;
    assign load_wdata_reg  = 1'b0;
    assign line_datain_sel = 1'b0;
    assign address_sel     = 1'b0;
    assign rdata_sel       = 1'b0;

    sat_counter #(.WIDTH(CTR_WIDTH)) u_hit_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clear),
        .inc   (hit_inc),
        .count (hit_count)
    );

    sat_counter #(.WIDTH(CTR_WIDTH)) u_miss_ctr (
        .clk   (clk),
        .rst   (rst),
        .clear (ctr_clear),
        .inc   (miss_inc),
        .count (miss_count)
    );

endmodule

// File: tb/tb_icache_control.sv
// Scoreboard bench for icache_control: driver pushes expected response latencies,
// a negedge monitor pops and compares on each mem_resp.
module tb_icache_control;

    localparam int W    = 4;
    localparam int MAXC = 15;

    logic         clk = 1'b0;
    logic         rst, mem_read, pmem_resp, hit, ctr_clear;
    logic         mem_resp, pmem_read, way_sel_method, load_line_data, load_valid, valid_in, load_LRU;
    logic         load_dirty, dirty_in, load_wdata_reg, line_datain_sel, address_sel, rdata_sel, busy;
    logic [W-1:0] hit_count, miss_count;

    icache_control #(.CTR_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_resp(pmem_resp), .hit(hit),
        .way_sel_method(way_sel_method), .load_line_data(load_line_data),
        .load_valid(load_valid), .valid_in(valid_in), .load_LRU(load_LRU),
        .load_dirty(load_dirty), .dirty_in(dirty_in), .load_wdata_reg(load_wdata_reg),
        .line_datain_sel(line_datain_sel), .address_sel(address_sel), .rdata_sel(rdata_sel),
        .ctr_clear(ctr_clear), .hit_count(hit_count), .miss_count(miss_count), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int expq[$];
    int pmem_cycles = 0, fill_pulses = 0, resp_count = 0, lru_count = 0;
    int lat = 0;
    int hit_m = 0, miss_m = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    // Monitor: observes outputs mid-cycle, independent of the driver.
    always @(negedge clk) begin
        int e;
        if (rst) begin
            check("reset_outputs_zero",
                  {mem_resp, pmem_read, way_sel_method, load_line_data, load_valid, valid_in,
                   load_LRU, busy, hit_count, miss_count}, 64'd0);
            lat = 0;
        end else begin
            if (pmem_read)      pmem_cycles++;
            if (load_line_data) fill_pulses++;
            if (load_LRU)       lru_count++;
            if (mem_resp)       resp_count++;
            check("tied_zero", {load_dirty, dirty_in, load_wdata_reg, line_datain_sel,
                                address_sel, rdata_sel}, 64'd0);
            if (mem_resp || load_LRU) check("lru_with_resp", load_LRU, mem_resp);
            if (load_line_data || load_valid || valid_in)
                check("fill_controls", {load_line_data, load_valid, valid_in}, 64'd7);
            if (way_sel_method || pmem_read) check("way_sel_fetch", way_sel_method, pmem_read);
            if (mem_resp) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_resp: got mem_resp=1 expected none at %0t", $time);
                end else begin
                    e = expq.pop_front();
                    check("resp_latency", lat, e);
                end
            end
            if (mem_read && !mem_resp) lat++;
            else lat = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"}, hit_count, hit_m);
        check({tag, "_miss_count"}, miss_count, miss_m);
    endtask

    task automatic do_hit();
        mem_read = 1'b1;
        hit      = 1'b1;
        expq.push_back(0);
        hit_m = sat(hit_m + 1);
        step();
        mem_read = 1'b0;
        hit      = 1'($urandom);
    endtask

    // Miss with d FETCH cycles; abort_at>0 drops mem_read in that FETCH cycle.
    task automatic do_miss(input int d, input int abort_at);
        int p0, f0, r0;
        p0 = pmem_cycles; f0 = fill_pulses; r0 = resp_count;
        mem_read = 1'b1;
        hit      = 1'b0;
        miss_m   = sat(miss_m + 1);
        if (abort_at == 0) expq.push_back(d + 2);
        step();
        for (int k = 1; k <= d; k++) begin
            hit = 1'($urandom);
            if (abort_at != 0 && k >= abort_at) mem_read = 1'b0;
            pmem_resp = (k == d);
            step();
        end
        pmem_resp = 1'b0;
        check("settle_busy", busy, 1);
        check("settle_pmem_read", pmem_read, 0);
        hit = 1'b1;
        step();
        if (abort_at != 0) begin
            check("abort_idle_busy", busy, 0);
            step();
        end else begin
            step();
            mem_read = 1'b0;
        end
        hit = 1'($urandom);
        check("miss_pmem_cycles", pmem_cycles - p0, d);
        check("miss_fill_pulses", fill_pulses - f0, 1);
        check("miss_resp_count", resp_count - r0, (abort_at != 0) ? 0 : 1);
    endtask

    initial begin
        int p0, f0, r0, l0, d;
        rst = 1'b1; mem_read = 1'b0; pmem_resp = 1'b0; hit = 1'b0; ctr_clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_counters("reset");
        check("reset_busy", busy, 0);
        rst = 1'b0;
        step();

        // Cold start miss with a 5-cycle memory
        do_miss(5, 0);
        check_counters("cold");

        // 10 back-to-back hits
        r0 = resp_count; l0 = lru_count;
        mem_read = 1'b1; hit = 1'b1;
        for (int i = 0; i < 10; i++) begin
            expq.push_back(0);
            hit_m = sat(hit_m + 1);
            step();
        end
        mem_read = 1'b0;
        step();
        check("b2b_resp", resp_count - r0, 10);
        check("b2b_lru", lru_count - l0, 10);
        check_counters("b2b");

        // Saturation: 17 hits total on a 4-bit counter
        for (int i = 0; i < 7; i++) do_hit();
        check_counters("sat");

        // Clear with a concurrent hit
        mem_read = 1'b1; hit = 1'b1; ctr_clear = 1'b1;
        expq.push_back(0);
        step();
        mem_read = 1'b0; ctr_clear = 1'b0;
        hit_m = 0; miss_m = 0;
        check_counters("clear");

        // Abort: mem_read dropped 2 cycles into FETCH, pmem_resp at cycle 4
        do_miss(4, 2);
        check_counters("abort");

        // Idle with random hit: nothing moves
        for (int i = 0; i < 3; i++) begin
            hit = 1'($urandom);
            step();
        end
        check("idle_busy", busy, 0);
        check_counters("idle");

        // Reset mid-FETCH: rst in cycle 3, late pmem_resp in cycle 5
        p0 = pmem_cycles; f0 = fill_pulses;
        mem_read = 1'b1; hit = 1'b0;
        step(); step(); step();
        #3;
        rst = 1'b1; hit = 1'b1;
        #1;
        check("rst_pmem_read", pmem_read, 0);
        check("rst_busy", busy, 0);
        check("rst_mem_resp", mem_resp, 0);
        hit_m = 0; miss_m = 0;
        expq.delete();
        check_counters("rst_mid");
        step();
        rst = 1'b0; mem_read = 1'b0;
        step();
        pmem_resp = 1'b1;
        step();
        pmem_resp = 1'b0;
        step();
        check("late_resp_pmem_cycles", pmem_cycles - p0, 2);
        check("late_resp_no_fill", fill_pulses - f0, 0);
        check("late_resp_busy", busy, 0);
        check_counters("late_resp");

        // Randomized transaction mix
        for (int t = 0; t < 60; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: do_hit();
                5, 6, 7:       do_miss(int'($urandom_range(1, 6)), 0);
                default: begin
                    d = int'($urandom_range(2, 6));
                    do_miss(d, int'($urandom_range(1, d)));
                end
            endcase
            repeat ($urandom_range(0, 2)) begin
                hit = 1'($urandom);
                step();
            end
            check_counters("rand");
        end

        step();
        check("queue_drained", expq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
